// File: rtl/ff_serializer.sv
// Parallel-to-serial feeder for a single-bit enabled flop: valid/ready word load, one bit per cycle out.
// Optional FF_SER_PARITY_EN appends an even-parity bit after the data bits.
module ff_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             d_out,
    output logic             d_en,
    output logic             busy,
    output logic             done
);

`ifdef FF_SER_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int CW = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d_out_q, d_out_d;
    logic             d_en_q, d_en_d;
    logic             done_q, done_d;
    logic             data_bit;
    logic [WIDTH-1:0] shift_next;
`ifdef FF_SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Bit order is fixed at elaboration; the word is consumed from one end.
    generate
        if (MSB_FIRST) begin : g_msb
            assign data_bit   = shift_q[WIDTH-1];
            assign shift_next = {shift_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign data_bit   = shift_q[0];
            assign shift_next = {1'b0, shift_q[WIDTH-1:1]};
        end
    endgenerate

    assign load_ready = (state_q == S_IDLE) && en;
    assign busy       = (state_q != S_IDLE);
    assign d_out      = d_out_q;
    assign d_en       = d_en_q;
    assign done       = done_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        d_out_d = d_out_q;
        d_en_d  = 1'b0;
        done_d  = 1'b0;
`ifdef FF_SER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load_valid && load_ready) begin
                    shift_d = load_data;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
`ifdef FF_SER_PARITY_EN
                    parity_d = ^load_data;
`endif
                end
            end
            S_SHIFT: begin
                if (en) begin
`ifdef FF_SER_PARITY_EN
                    if (cnt_q < CW'(WIDTH)) begin
                        d_out_d = data_bit;
                        shift_d = shift_next;
                    end else begin
                        d_out_d = parity_q;
                    end
`else
                    d_out_d = data_bit;
                    shift_d = shift_next;
`endif
                    d_en_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(FRAME_BITS - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (en) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            d_out_q <= 1'b0;
            d_en_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FF_SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            d_out_q <= d_out_d;
            d_en_q  <= d_en_d;
            done_q  <= done_d;
`ifdef FF_SER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_ff_serializer.sv
// Directed bench for ff_serializer: one MSB-first and one LSB-first instance share clock, clr and en.
// Expected serial streams are written out by hand, first bit at the left, 9th (parity) bit last.
module tb_ff_serializer;

`ifdef FF_SER_PARITY_EN
    localparam int FB = 9;
`else
    localparam int FB = 8;
`endif

    logic       clk;
    logic       clr;
    logic       en;
    logic       valid;
    logic       sel;
    logic [7:0] data;

    logic valid_a, ready_a, dout_a, den_a, busy_a, done_a;
    logic valid_b, ready_b, dout_b, den_b, busy_b, done_b;
    logic ready, dout, den, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    assign valid_a = valid & ~sel;
    assign valid_b = valid & sel;
    assign ready   = sel ? ready_b : ready_a;
    assign dout    = sel ? dout_b  : dout_a;
    assign den     = sel ? den_b   : den_a;
    assign busy    = sel ? busy_b  : busy_a;
    assign done    = sel ? done_b  : done_a;

    ff_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .clr(clr), .en(en),
        .load_valid(valid_a), .load_ready(ready_a), .load_data(data),
        .d_out(dout_a), .d_en(den_a), .busy(busy_a), .done(done_a)
    );

    ff_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .clr(clr), .en(en),
        .load_valid(valid_b), .load_ready(ready_b), .load_data(data),
        .d_out(dout_b), .d_en(den_b), .busy(busy_b), .done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word, check the handshake, take the accept edge.
    task automatic start(input logic [7:0] word, input bit noise);
        data  = word;
        valid = 1'b1;
        #1;
        check("ready_before_accept", ready, 1'b1);
        tick();
        if (noise) data = 8'h00;
        else valid = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        check("done_after_accept", done, 1'b0);
        check("den_after_accept", den, 1'b0);
    endtask

    // Walk the frame bits, optionally dropping en for 3 cycles after bit gap_at,
    // and stop in the cycle where done is expected high.
    task automatic run_bits(input logic [8:0] stream, input int gap_at);
        for (int i = 0; i < FB; i++) begin
            tick();
            check($sformatf("den_bit%0d", i), den, 1'b1);
            check($sformatf("dout_bit%0d", i), dout, stream[8-i]);
            check($sformatf("busy_bit%0d", i), busy, 1'b1);
            check($sformatf("ready_bit%0d", i), ready, 1'b0);
            if (i + 1 == gap_at) begin
                en = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    tick();
                    check("gap_den", den, 1'b0);
                    check("gap_dout_hold", dout, stream[8-i]);
                    check("gap_busy", busy, 1'b1);
                    check("gap_done", done, 1'b0);
                end
                en = 1'b1;
            end
        end
        tick();
        check("den_at_done", den, 1'b0);
        check("done_pulse", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("ready_at_done", ready, 1'b1);
    endtask

    task automatic idle_tick();
        valid = 1'b0;
        tick();
        check("done_cleared", done, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("den_idle", den, 1'b0);
        check("ready_idle", ready, 1'b1);
    endtask

    initial begin
        clr   = 1'b1;
        en    = 1'b1;
        valid = 1'b0;
        sel   = 1'b0;
        data  = 8'h00;
        tick();
        tick();
        check("rst_dout", dout_a, 1'b0);
        check("rst_den", den_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_ready", ready_a, 1'b1);
        check("rst_ready_lsb", ready_b, 1'b1);
        clr = 1'b0;
        tick();

        // MSB-first A5
        start(8'hA5, 1'b0);
        run_bits(9'b1010_0101_0, 0);
        idle_tick();
        $display("frame msb 0xA5 complete");

        // LSB-first 01
        sel = 1'b1;
        start(8'h01, 1'b0);
        run_bits(9'b1000_0000_1, 0);
        idle_tick();
        $display("frame lsb 0x01 complete");
        sel = 1'b0;

        // C3 with an en gap after bit 3
        start(8'hC3, 1'b0);
        run_bits(9'b1100_0011_0, 3);
        idle_tick();
        $display("frame msb 0xC3 with en gap complete");

        // FF aborted by clr after bit 4
        start(8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_den", den, 1'b1);
            check("abort_dout", dout, 1'b1);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_den", den, 1'b0);
        check("clr_busy", busy, 1'b0);
        check("clr_ready", ready, 1'b1);
        check("clr_dout", dout, 1'b0);
        check("clr_done", done, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("no_done_after_clr", done, 1'b0);
            check("no_busy_after_clr", busy, 1'b0);
        end
        $display("frame msb 0xFF aborted by clr");

        // A5 with load_valid noise, then 3C back-to-back in the done cycle
        start(8'hA5, 1'b1);
        run_bits(9'b1010_0101_0, 0);
        start(8'h3C, 1'b0);
        run_bits(9'b0011_1100_0, 0);
        idle_tick();
        $display("frame msb 0xA5 with ignored valid, then 0x3C back-to-back");

        // 07: 9th bit is the parity bit (1) when enabled
        start(8'h07, 1'b0);
        run_bits(9'b0000_0111_1, 0);
        idle_tick();
        $display("frame msb 0x07 complete");

        // clr and load_valid together: nothing captured
        data  = 8'h55;
        valid = 1'b1;
        clr   = 1'b1;
        tick();
        clr   = 1'b0;
        valid = 1'b0;
        check("clr_vs_valid_busy", busy, 1'b0);
        tick();
        check("clr_vs_valid_busy2", busy, 1'b0);
        check("clr_vs_valid_den", den, 1'b0);

        // en low in IDLE: not ready, no capture
        en    = 1'b0;
        valid = 1'b1;
        #1;
        check("ready_en_low", ready, 1'b0);
        tick();
        check("no_capture_en_low", busy, 1'b0);
        valid = 1'b0;
        en    = 1'b1;
        #1;
        check("ready_en_high", ready, 1'b1);
        $display("idle corner cases done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
